// File: rtl/router_pkt_tx_pkg.sv
// rtl/router_pkt_tx_pkg.sv - shared types, constants and helpers for the packet transmitter
package router_pkt_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PLD  = 2'd2,
        ST_PAR  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

    // Feedback taps on bits 7,5,4,3; an all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_FIX = 8'h01;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] make_hdr(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - request and packet-output signal bundle for router_pkt_tx
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] length;
    logic       mode;
    logic [7:0] seed;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       done;
    logic       req_err;

    modport slave (
        input  start, dest_addr, length, mode, seed, busy,
        output pkt_valid, data_out, tx_active, done, req_err
    );

    modport master (
        output start, dest_addr, length, mode, seed, busy,
        input  pkt_valid, data_out, tx_active, done, req_err
    );
endinterface

// File: rtl/router_pat_gen.sv
// rtl/router_pat_gen.sv - payload pattern generator: incrementing or 8-bit LFSR sequence
module router_pat_gen
    import router_pkt_tx_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic       load_mode,
    input  logic [7:0] load_seed,
    input  logic       advance,
    output logic [7:0] cur,
    output logic [7:0] nxt
);

    logic       mode_q, mode_d;
    logic [7:0] pat_q, pat_d;

    assign cur = pat_q;
    assign nxt = mode_q ? lfsr_next(pat_q) : pat_q + 8'd1;

    always_comb begin
        mode_d = mode_q;
        pat_d  = pat_q;
        if (load) begin
            mode_d = load_mode;
            pat_d  = (load_mode && (load_seed == 8'd0)) ? LFSR_ZERO_FIX : load_seed;
        end else if (advance) begin
            pat_d = nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mode_q <= 1'b0;
            pat_q  <= 8'd0;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet transmitter FSM: header, generated payload, XOR parity byte
module router_pkt_tx
    import router_pkt_tx_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    router_pkt_tx_if.slave  bus
);

    state_e     state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] par_q, par_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       pat_load, pat_adv;
    logic [7:0] pat_cur, pat_nxt;
    logic       accept;

    router_pat_gen u_pat_gen (
        .clock     (clock),
        .resetn    (resetn),
        .load      (pat_load),
        .load_mode (bus.mode),
        .load_seed (bus.seed),
        .advance   (pat_adv),
        .cur       (pat_cur),
        .nxt       (pat_nxt)
    );

    assign accept = (state_q != ST_IDLE) && !bus.busy;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        data_d   = data_q;
        valid_d  = valid_q;
        active_d = active_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        pat_load = 1'b0;
        pat_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((bus.dest_addr == ADDR_ILLEGAL) || (bus.length == 6'd0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = ST_HDR;
                        len_d    = bus.length;
                        cnt_d    = 6'd0;
                        par_d    = 8'd0;
                        data_d   = make_hdr(bus.length, bus.dest_addr);
                        valid_d  = 1'b1;
                        active_d = 1'b1;
                        pat_load = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (accept) begin
                    state_d = ST_PLD;
                    par_d   = par_q ^ data_q;
                    data_d  = pat_cur;
                end
            end
            ST_PLD: begin
                if (accept) begin
                    par_d = par_q ^ data_q;
                    cnt_d = cnt_q + 6'd1;
                    // The parity byte folds in the payload byte being accepted this cycle.
                    if (cnt_q == len_q - 6'd1) begin
                        state_d = ST_PAR;
                        valid_d = 1'b0;
                        data_d  = par_q ^ data_q;
                    end else begin
                        data_d  = pat_nxt;
                        pat_adv = 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (accept) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    data_d   = 8'd0;
                    valid_d  = 1'b0;
                    active_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            len_q    <= 6'd0;
            cnt_q    <= 6'd0;
            par_q    <= 8'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.pkt_valid = valid_q;
    assign bus.data_out  = data_q;
    assign bus.tx_active = active_q;
    assign bus.done      = done_q;
    assign bus.req_err   = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - scoreboard testbench for router_pkt_tx
module tb_router_pkt_tx;

    typedef struct {
        logic [1:0] a;
        logic [5:0] l;
        logic       m;
        logic [7:0] s;
        logic [7:0] par;
    } pkt_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    logic clock;
    logic resetn;
    router_pkt_tx_if bus();

    router_pkt_tx dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   err_seen = 0;
    exp_t exp_q[$];
    logic noise_start = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected byte per accepted byte and checks stall stability.
    logic       hold_pending = 1'b0;
    logic [7:0] last_data;
    logic       last_valid;
    always @(negedge clock) begin
        exp_t e;
        if (resetn) begin
            if (hold_pending) begin
                chk("hold_data", bus.data_out, last_data);
                chk("hold_valid", bus.pkt_valid, last_valid);
            end
            if (bus.done) done_seen++;
            if (bus.req_err) err_seen++;
            if (bus.tx_active && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_data", bus.data_out, e.data);
                    chk("byte_valid", bus.pkt_valid, e.valid);
                end
            end
            hold_pending = bus.tx_active && bus.busy;
            last_data    = bus.data_out;
            last_valid   = bus.pkt_valid;
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pkt(input pkt_t p);
        logic [7:0] v;
        exp_t e;
        e.data = {p.l, p.a}; e.valid = 1'b1; exp_q.push_back(e);
        v = p.s;
        if (p.m && v == 8'd0) v = 8'h01;
        for (int k = 0; k < int'(p.l); k++) begin
            e.data = v; e.valid = 1'b1; exp_q.push_back(e);
            v = p.m ? {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]} : v + 8'd1;
        end
        e.data = p.par; e.valid = 1'b0; exp_q.push_back(e);
        bus.dest_addr = p.a;
        bus.length    = p.l;
        bus.mode      = p.m;
        bus.seed      = p.s;
        bus.start     = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic run_bytes(input int len, input int n_acc, input int s0, input int sp);
        int stall;
        for (int idx = 0; idx < n_acc; idx++) begin
            stall = (idx == 1) ? s0 : (idx == len + 1) ? sp : 0;
            bus.start = noise_start && (idx <= len);
            if (noise_start) begin
                bus.dest_addr = 2'd3;
                bus.length    = 6'd0;
            end
            bus.busy = 1'b1;
            repeat (stall) cyc();
            bus.busy = 1'b0;
            cyc();
        end
        bus.start = 1'b0;
    endtask

    task automatic send_full(input pkt_t p, input int s0, input int sp);
        start_pkt(p);
        run_bytes(int'(p.l), int'(p.l) + 2, s0, sp);
        chk("done_pulse", bus.done, 1);
    endtask

    task automatic idle_check(input string nm);
        cyc();
        chk({nm, "_done_low"}, bus.done, 0);
        chk({nm, "_idle_valid"}, bus.pkt_valid, 0);
        chk({nm, "_idle_data"}, bus.data_out, 0);
        chk({nm, "_idle_active"}, bus.tx_active, 0);
    endtask

    task automatic zero_outputs(input string nm);
        chk({nm, "_valid"}, bus.pkt_valid, 0);
        chk({nm, "_data"}, bus.data_out, 0);
        chk({nm, "_active"}, bus.tx_active, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_err"}, bus.req_err, 0);
    endtask

    initial begin
        pkt_t p;
        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.dest_addr = 2'd0;
        bus.length    = 6'd0;
        bus.mode      = 1'b0;
        bus.seed      = 8'd0;
        bus.busy      = 1'b0;
        repeat (3) cyc();
        zero_outputs("reset");
        resetn = 1'b1;
        cyc();

        // addr1 len2 incrementing from 0x10: 09 10 11, parity 08
        p = '{a: 2'd1, l: 6'd2, m: 1'b0, s: 8'h10, par: 8'h08};
        send_full(p, 0, 0);
        idle_check("p031");

        // addr2 len3 LFSR zero seed: 0E 01 02 04, parity 09
        p = '{a: 2'd2, l: 6'd3, m: 1'b1, s: 8'h00, par: 8'h09};
        send_full(p, 0, 0);
        idle_check("p032");

        // Stalls on payload 0 and parity, with illegal starts issued mid-packet
        p = '{a: 2'd1, l: 6'd2, m: 1'b0, s: 8'h10, par: 8'h08};
        noise_start = 1'b1;
        send_full(p, 3, 2);
        noise_start = 1'b0;
        idle_check("p033");

        bus.dest_addr = 2'd3; bus.length = 6'd5; bus.start = 1'b1;
        cyc();
        chk("err_addr", bus.req_err, 1);
        chk("err_addr_valid", bus.pkt_valid, 0);
        chk("err_addr_active", bus.tx_active, 0);
        bus.dest_addr = 2'd0; bus.length = 6'd0;
        cyc();
        chk("err_len", bus.req_err, 1);
        chk("err_len_valid", bus.pkt_valid, 0);
        bus.start = 1'b0;
        cyc();
        chk("err_one_cycle", bus.req_err, 0);
        p = '{a: 2'd0, l: 6'd1, m: 1'b0, s: 8'h55, par: 8'h51};
        send_full(p, 0, 0);
        idle_check("p034");

        // Back-to-back: second start lands in the done cycle
        p = '{a: 2'd0, l: 6'd2, m: 1'b0, s: 8'hF0, par: 8'h09};
        send_full(p, 0, 0);
        p = '{a: 2'd1, l: 6'd2, m: 1'b1, s: 8'h80, par: 8'h88};
        start_pkt(p);
        chk("b2b_done_low", bus.done, 0);
        chk("b2b_hdr_data", bus.data_out, 8'h09);
        chk("b2b_hdr_valid", bus.pkt_valid, 1);
        run_bytes(2, 4, 0, 0);
        chk("b2b_done", bus.done, 1);
        idle_check("p036");

        // Reset during payload of a len=10 packet
        p = '{a: 2'd1, l: 6'd10, m: 1'b0, s: 8'h20, par: 8'h00};
        start_pkt(p);
        run_bytes(10, 4, 0, 0);
        chk("pre_reset_active", bus.tx_active, 1);
        resetn = 1'b0;
        #1;
        zero_outputs("async_reset");
        exp_q.delete();
        repeat (2) cyc();
        resetn = 1'b1;
        repeat (3) cyc();
        chk("post_reset_idle", bus.tx_active, 0);
        p = '{a: 2'd0, l: 6'd1, m: 1'b0, s: 8'hAA, par: 8'hAE};
        send_full(p, 0, 0);
        idle_check("p035");

        repeat (2) cyc();
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_seen, 7);
        chk("req_err_count", err_seen, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock  input  1  rising-edge clock; resetn  input  1  async active-low reset.
REQ-002 start  input  1  request to send one packet; sampled only in IDLE.
REQ-003 dest_addr  input  2  destination port; 0..2 valid, 3 illegal.
REQ-004 length  input  6  payload byte count; 1..63 valid, 0 illegal.
REQ-005 mode  input  1  payload pattern: 0 incrementing, 1 LFSR.
REQ-006 seed  input  8  first payload pattern value.
REQ-007 busy  input  1  router busy; when high, the byte on data_out is not accepted and SHALL be held.
REQ-008 pkt_valid  output  1  high for header and payload bytes, low for the parity byte and when idle.
REQ-009 data_out  output  8  packet byte: header, payload, or parity.
REQ-010 tx_active  output  1  high in HDR, PLD and PAR.
REQ-011 done  output  1  one-cycle pulse after the parity byte is accepted.
REQ-012 req_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-013 The FSM states SHALL be IDLE, HDR, PLD and PAR, and all outputs SHALL be registered.
REQ-014 Accept SHALL mean: state is HDR, PLD or PAR and busy==0 at the clock edge.
REQ-015 IDLE + start + legal params: latch addr, length, mode and seed; next cycle HDR, pkt_valid=1, data_out={length,dest_addr}.
REQ-016 IDLE + start + illegal params (addr==3 or length==0): stay in IDLE; req_err=1 for one cycle.
REQ-017 Start outside IDLE SHALL be ignored with no req_err.
REQ-018 Header accept: go to PLD; data_out=payload byte 0; pkt_valid=1.
REQ-019 PLD: 6-bit counter of accepted payload bytes; accepting byte length-1 enters PAR with pkt_valid=0 and data_out=parity.
REQ-020 Mode 0: payload byte k = (seed+k) mod 256.
REQ-021 Mode 1: byte 0 = seed, or 0x01 if seed==0; next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
REQ-022 Parity SHALL be the XOR of the header and all payload bytes, accumulated on each accept and cleared on a packet start.
REQ-023 PAR accept: go to IDLE; done=1 for that one cycle; data_out=0x00; pkt_valid=0.
REQ-024 busy high: state, counter, pattern, parity, data_out and pkt_valid all SHALL hold, for any stall length including stalls on the header and parity bytes.
REQ-025 Back-to-back packets: start is accepted in the cycle done is high; the minimum gap between packets is one IDLE cycle.
REQ-026 In IDLE: pkt_valid=0, data_out=0x00, tx_active=0.

Reset
REQ-027 resetn low SHALL immediately (asynchronously) force IDLE and clear every register; all outputs SHALL be 0.
REQ-028 Reset mid-packet SHALL abandon the packet; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-029 A shared package SHALL hold: the state enum, ADDR_ILLEGAL=2'd3, the LFSR tap constants, and header field positions (length [7:2], addr [1:0]).
REQ-030 The pattern generator (incrementing/LFSR, load and advance) SHALL be the sub-module router_pat_gen; the FSM, counter and parity stay in router_pkt_tx.

Verification
REQ-031 addr=1, len=2, mode=0, seed=0x10, busy=0 -> bytes 0x09, 0x10, 0x11 with pkt_valid=1; then 0x08 with pkt_valid=0; done pulses once.
REQ-032 addr=2, len=3, mode=1, seed=0x00 -> 0x0E, 0x01, 0x02, 0x04; parity 0x09.
REQ-033 As REQ-031 with busy high for 3 cycles on payload byte 0 and 2 cycles on parity -> bytes held stable; same sequence; done once.
REQ-034 start with addr=3 or len=0 -> req_err one cycle; pkt_valid stays 0; next legal start succeeds.
REQ-035 resetn low during PLD of a len=10 packet -> outputs 0 asynchronously; a new addr=0, len=1, seed=0xAA packet gives 0x04, 0xAA, parity 0xAE.
REQ-036 Start in the same cycle as done (back-to-back) -> second header appears one cycle after done; parity is not carried over from the first packet.
